// File: rtl/vga_sync.sv
// VGA timing generator: pixel-strobe divider, h/v counters, zero-lag registered syncs, VGA_FRAME_CNT_EN adds frame_cnt.
// Latency: x/y/hsync/vsync all update on the same edge; no backpressure, free-running.
module vga_sync #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);

    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             tick;
    logic             line_end;
    logic             frame_end;

    // Wraps use >= so any corrupted count falls back into range on the next step.
    always_comb begin
        tick      = (div_q == DIV_MAX);
        div_d     = (div_q >= DIV_MAX) ? '0 : div_q + 1'b1;
        line_end  = tick && (h_q >= H_MAX);
        frame_end = line_end && (v_q >= V_MAX);

        h_d = h_q;
        v_d = v_q;
        if (tick) begin
            h_d = line_end ? 10'd0 : h_q + 10'd1;
        end
        if (line_end) begin
            v_d = frame_end ? 10'd0 : v_q + 10'd1;
        end

        // Syncs decode the next-state counts so the registered pins line up with x/y.
        hsync_d = !((h_d >= HS_START) && (h_d <= HS_END));
        vsync_d = !((v_d >= VS_START) && (v_d <= VS_END));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            h_q     <= 10'd0;
            v_q     <= 10'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= 8'd0;
        end else if (frame_end) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign p_tick   = tick;
    assign x        = h_q;
    assign y        = v_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign video_on = (h_q < H_VIS) && (v_q < V_VIS);

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync with a shrunken raster so many frames, the frame counter wrap and random async resets fit the run.
module tb_vga_sync;

    localparam int HD = 4;
    localparam int HF = 1;
    localparam int HS = 2;
    localparam int HB = 1;
    localparam int VD = 3;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int DIV = 4;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FRAME_CLKS = HT * VT * DIV;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       von;
        logic       pt;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] fc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    vga_sync #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLK_DIV(DIV)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .hsync    (hsync),
        .vsync    (vsync),
        .video_on (video_on),
        .p_tick   (p_tick),
        .x        (x),
        .y        (y)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   k = 0;
    bit   started = 0;

    // Reference: after k live edges, k/DIV pixel strobes have completed; everything follows by division.
    function automatic exp_t model(input int edges);
        exp_t e;
        int ticks = edges / DIV;
        int pix   = ticks % (HT * VT);
        int h     = pix % HT;
        int v     = pix / HT;
        e.pt  = ((edges % DIV) == DIV - 1);
        e.x   = 10'(h);
        e.y   = 10'(v);
        e.hs  = !(h >= HD + HF && h < HD + HF + HS);
        e.vs  = !(v >= VD + VF && v < VD + VF + VS);
        e.von = (h < HD) && (v < VD);
        e.fc  = 8'((ticks / (HT * VT)) % 256);
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t, model edges=%0d)", name, act, req, $time, k);
        end
    endtask

    // One clock: count the edge if the DUT was live, then optionally change reset mid-cycle.
    task automatic step(input logic rst_n_next);
        int d;
        @(posedge clk);
        if (reset_n) k++;
        d = 1 + $urandom_range(0, 2);
        #d;
        reset_n = rst_n_next;
        if (!reset_n) k = 0;
        exp_q.push_back(model(k));
        started = 1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (started) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check("x",        int'(x),        int'(e.x));
                    check("y",        int'(y),        int'(e.y));
                    check("hsync",    int'(hsync),    int'(e.hs));
                    check("vsync",    int'(vsync),    int'(e.vs));
                    check("video_on", int'(video_on), int'(e.von));
                    check("p_tick",   int'(p_tick),   int'(e.pt));
`ifdef VGA_FRAME_CNT_EN
                    check("frame_cnt", int'(frame_cnt), int'(e.fc));
`endif
                end
            end
        end
    end

    initial begin : stimulus
        int hold;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0);
        step(1'b1);
        run(2 * FRAME_CLKS + 37);

        // Random asynchronous reset pulses landing mid-line and mid-frame.
        for (int r = 0; r < 12; r++) begin
            run($urandom_range(1, 3 * FRAME_CLKS));
            hold = $urandom_range(1, 3);
            for (int i = 0; i < hold; i++) step(1'b0);
            step(1'b1);
        end

        // Long run so the frame counter wraps past 255.
        run(257 * FRAME_CLKS + 50);

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 Parameter H_DISPLAY, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, 48, horizontal back porch in pixels.
REQ-005 Parameter V_DISPLAY, 480, visible lines per frame.
REQ-006 Parameter V_FRONT, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, 33, vertical back porch in lines.
REQ-009 Parameter CLK_DIV, 4, system clocks per pixel (integer >= 2).
REQ-010 clk  input  1  system clock, all logic on rising edge.
REQ-011 reset_n  input  1  asynchronous active-low reset.
REQ-012 hsync  output  1  horizontal sync, active low, registered.
REQ-013 vsync  output  1  vertical sync, active low, registered.
REQ-014 video_on  output  1  high while pixel is in the visible region.
REQ-015 p_tick  output  1  one-clk pixel strobe.
REQ-016 x  output  10  current pixel column (h_count).
REQ-017 y  output  10  current line (v_count).
REQ-018 frame_cnt  output  8  completed-frame count (only when VGA_FRAME_CNT_EN is defined).

Function
REQ-019 The block SHALL keep a clock divider counting 0..CLK_DIV-1, wrapping to 0; p_tick SHALL be high exactly in the clk cycles where the divider equals CLK_DIV-1.
REQ-020 h_count SHALL advance by 1 only on clk edges where p_tick is high, wrapping from H_TOTAL-1 to 0, H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800).
REQ-021 v_count SHALL advance by 1 only on the edge where p_tick is high and h_count = H_TOTAL-1, wrapping from V_TOTAL-1 to 0, V_TOTAL = 525; simultaneous h and v wrap at (799,524) SHALL yield (0,0).
REQ-022 x SHALL equal h_count and y SHALL equal v_count, zero-extended to 10 bits.
REQ-023 video_on SHALL be combinational: high iff h_count < H_DISPLAY and v_count < V_DISPLAY.
REQ-024 hsync SHALL be low iff h_count in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656,751], registered from next-state count so it changes on the same edge as h_count (zero lag vs x).
REQ-025 vsync SHALL be low iff v_count in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = [490,491], registered likewise, same edge as v_count.
REQ-026 Counter widths SHALL be 10 bits; no count SHALL ever exceed TOTAL-1 (no out-of-range state reachable).
REQ-027 Line period SHALL be H_TOTAL*CLK_DIV clks (3200); frame period H_TOTAL*V_TOTAL*CLK_DIV clks (1,680,000).

Reset
REQ-028 While reset_n is low: divider=0, h_count=0, v_count=0, x=0, y=0, p_tick=0, hsync=1, vsync=1, video_on=1, frame_cnt=0; assertion SHALL take effect asynchronously, mid-line or mid-frame.
REQ-029 After reset_n rises, the first p_tick SHALL occur on clk cycle CLK_DIV (divider reaching CLK_DIV-1), and the first count advance on that cycle's rising edge.

Configuration
REQ-030 Macro VGA_FRAME_CNT_EN defined: port frame_cnt present; increments by 1 on the edge where (h_count,v_count) wraps from (799,524) to (0,0); wraps 255->0.
REQ-031 Macro VGA_FRAME_CNT_EN undefined: port frame_cnt and its register absent; all other behaviour identical.

Verification
REQ-032 Reset release, count clks -> p_tick pulses every 4 clks, first at clk 4; x steps 0->1 on that edge.
REQ-033 Run one line -> hsync low for exactly 96 pixels starting x=656, high again at x=752; x wraps 799->0 and y 0->1 on same edge.
REQ-034 Run one frame -> vsync low for exactly 2 lines (y=490,491); video_on low for x=640..799 and all of y=480..524; 1,680,000 clks per frame.
REQ-035 At (799,524) with p_tick -> next (0,0), video_on 1, frame_cnt +1; after 256 frames frame_cnt returns to 0 (VGA_FRAME_CNT_EN defined).
REQ-036 Assert reset_n low at x=700,y=300 between clk edges -> immediately x=0,y=0,hsync=1,vsync=1,p_tick=0; resumes per REQ-029.
REQ-037 Build without VGA_FRAME_CNT_EN -> elaborates without frame_cnt; REQ-032..034 results unchanged.
